// File: rtl/ascon_squeeze.sv
// Ascon squeeze stage: streams x0 as 64-bit output blocks and runs the shared
// p12 permutation between blocks until the requested byte count is delivered.
module ascon_squeeze #(
    parameter int unsigned HASH_LEN_BYTES = 32,
    parameter int unsigned LEN_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       sel_type,
    input  logic [LEN_W-1:0] out_length,
    input  logic [63:0]      x0_i,
    input  logic [63:0]      x1_i,
    input  logic [63:0]      x2_i,
    input  logic [63:0]      x3_i,
    input  logic [63:0]      x4_i,
    output logic [63:0]      out_data,
    output logic [3:0]       out_bytes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [63:0]      x0_o,
    output logic [63:0]      x1_o,
    output logic [63:0]      x2_o,
    output logic [63:0]      x3_o,
    output logic [63:0]      x4_o,
    output logic [63:0]      x0_i_SQ_p12,
    output logic [63:0]      x1_i_SQ_p12,
    output logic [63:0]      x2_i_SQ_p12,
    output logic [63:0]      x3_i_SQ_p12,
    output logic [63:0]      x4_i_SQ_p12,
    input  logic [63:0]      x0_o_SQ_p12,
    input  logic [63:0]      x1_o_SQ_p12,
    input  logic [63:0]      x2_o_SQ_p12,
    input  logic [63:0]      x3_o_SQ_p12,
    input  logic [63:0]      x4_o_SQ_p12
);

    typedef enum logic [1:0] {StIdle, StEmit, StPerm, StDone} state_e;

    localparam logic [1:0] SelAead = 2'b00;
    localparam logic [1:0] SelHash = 2'b01;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q;
    logic [63:0]      x0_q, x1_q, x2_q, x3_q, x4_q;

    logic       accept;
    logic       has_data;
    logic       final_blk;
    logic       handshake;
    logic [3:0] chunk;

    assign accept    = (state_q == StIdle) && start && (sel_type != SelAead);
    assign has_data  = (remaining_q != '0);
    assign final_blk = (remaining_q <= LEN_W'(8));
    assign chunk     = final_blk ? remaining_q[3:0] : 4'd8;
    assign handshake = (state_q == StEmit) && has_data && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero-length request spends its EMIT cycle silently so busy covers two cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StEmit;
            StEmit: begin
                if (!has_data) begin
                    state_d = StDone;
                end else if (out_ready) begin
                    state_d = final_blk ? StDone : StPerm;
                end
            end
            StPerm:  state_d = StEmit;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            x4_q        <= '0;
        end else if (accept) begin
            remaining_q <= (sel_type == SelHash) ? LEN_W'(HASH_LEN_BYTES) : out_length;
            x0_q        <= x0_i;
            x1_q        <= x1_i;
            x2_q        <= x2_i;
            x3_q        <= x3_i;
            x4_q        <= x4_i;
        end else if (state_q == StPerm) begin
            x0_q <= x0_o_SQ_p12;
            x1_q <= x1_o_SQ_p12;
            x2_q <= x2_o_SQ_p12;
            x3_q <= x3_o_SQ_p12;
            x4_q <= x4_o_SQ_p12;
        end else if (handshake) begin
            remaining_q <= remaining_q - LEN_W'(chunk);
        end
    end

    always_comb begin
        out_valid = (state_q == StEmit) && has_data;
        out_bytes = out_valid ? chunk : 4'd0;
        out_last  = out_valid && final_blk;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        out_data  = '0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid && (4'(k) < chunk)) begin
                out_data[8*k +: 8] = x0_q[8*k +: 8];
            end
        end
    end

    assign x0_o = x0_q;
    assign x1_o = x1_q;
    assign x2_o = x2_q;
    assign x3_o = x3_q;
    assign x4_o = x4_q;

    assign x0_i_SQ_p12 = x0_q;
    assign x1_i_SQ_p12 = x1_q;
    assign x2_i_SQ_p12 = x2_q;
    assign x3_i_SQ_p12 = x3_q;
    assign x4_i_SQ_p12 = x4_q;

endmodule

// File: tb/tb_ascon_squeeze.sv
// Bench for ascon_squeeze: reference p12 drives the permutation ports; table of
// squeeze requests plus hand-written backpressure, AEAD-ignore and reset sequences.
module tb_ascon_squeeze;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  sel_type;
    logic [31:0] out_length;
    logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
    logic [63:0] out_data;
    logic [3:0]  out_bytes;
    logic        out_valid, out_ready, out_last, busy, done;
    logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
    logic [63:0] p0_in, p1_in, p2_in, p3_in, p4_in;
    logic [63:0] p0_out, p1_out, p2_out, p3_out, p4_out;
    bit          perm_mode;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [63:0] X1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] X2 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] X3 = 64'h0F0F_0F0F_F0F0_F0F0;
    localparam logic [63:0] X4 = 64'h8000_0000_0000_0001;

    always #5 clk = ~clk;

    ascon_squeeze #(.HASH_LEN_BYTES(32), .LEN_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel_type(sel_type), .out_length(out_length),
        .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
        .out_data(out_data), .out_bytes(out_bytes), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
        .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o), .x4_o(x4_o),
        .x0_i_SQ_p12(p0_in), .x1_i_SQ_p12(p1_in), .x2_i_SQ_p12(p2_in),
        .x3_i_SQ_p12(p3_in), .x4_i_SQ_p12(p4_in),
        .x0_o_SQ_p12(p0_out), .x1_o_SQ_p12(p1_out), .x2_o_SQ_p12(p2_out),
        .x3_o_SQ_p12(p3_out), .x4_o_SQ_p12(p4_out)
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // State packed as {x4,x3,x2,x1,x0}; x0 in the low word.
    function automatic logic [319:0] p12(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x4, x3, x2, x1, x0} = s;
        for (int r = 0; r < 12; r++) begin
            x2 = x2 ^ 64'(((15 - r) << 4) | r);
            x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
            x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
            x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
            x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
            x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
            x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
            x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
        end
        return {x4, x3, x2, x1, x0};
    endfunction

    // Mode 1 stands in for a permutation whose x0 result is all ones.
    function automatic logic [319:0] perm(input logic [319:0] s, input bit mode);
        if (mode) return {s[319:64], 64'hFFFF_FFFF_FFFF_FFFF};
        return p12(s);
    endfunction

    function automatic logic [63:0] mask(input logic [63:0] x, input int n);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < n; k++) m[8*k +: 8] = x[8*k +: 8];
        return m;
    endfunction

    always_comb begin
        {p4_out, p3_out, p2_out, p1_out, p0_out} =
            perm({p4_in, p3_in, p2_in, p1_in, p0_in}, perm_mode);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] len;
        logic [63:0] x0;
        bit          mode;
        bit          noise;
        int          blocks;
        int          last_bytes;
    } vec_t;

    task automatic drive_start(input logic [1:0] sel, input logic [31:0] len,
                               input logic [63:0] x0);
        @(negedge clk);
        start = 1'b1; sel_type = sel; out_length = len;
        x0_i = x0; x1_i = X1; x2_i = X2; x3_i = X3; x4_i = X4;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [319:0] st;
        int nb;
        perm_mode = v.mode;
        st = {X4, X3, X2, X1, v.x0};
        drive_start(v.sel, v.len, v.x0);
        start = v.noise;
        if (v.noise) begin
            sel_type = 2'b10; out_length = 32'd3; x0_i = '0;
        end
        if (v.blocks == 0) begin
            @(negedge clk);
            chk("zero_len_valid", 64'(out_valid), 64'd0);
            chk("zero_len_busy", 64'(busy), 64'd1);
            chk("zero_len_early_done", 64'(done), 64'd0);
        end
        for (int b = 0; b < v.blocks; b++) begin
            nb = (b == v.blocks - 1) ? v.last_bytes : 8;
            if (b > 0) begin
                @(negedge clk);
                chk("perm_valid_low", 64'(out_valid), 64'd0);
                chk("perm_busy", 64'(busy), 64'd1);
            end
            @(negedge clk);
            chk("blk_valid", 64'(out_valid), 64'd1);
            chk("blk_data", out_data, mask(st[63:0], nb));
            chk("blk_bytes", 64'(out_bytes), 64'(nb));
            chk("blk_last", 64'(out_last), 64'(b == v.blocks - 1));
            if (b != v.blocks - 1) st = perm(st, v.mode);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_valid", 64'(out_valid), 64'd0);
        chk("final_x0", x0_o, st[63:0]);
        chk("final_x4", x4_o, st[319:256]);
        @(negedge clk);
        chk("after_done", 64'(done), 64'd0);
        chk("after_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        logic [319:0] st;
        logic [63:0]  held;

        //          sel    len     x0                      mode noise blocks last
        tbl[0] = '{2'b01, 32'd5,  64'h0123456789ABCDEF, 1'b0, 1'b0, 4, 8};
        tbl[1] = '{2'b10, 32'd13, 64'h55AA55AA12345678, 1'b1, 1'b0, 2, 5};
        tbl[2] = '{2'b10, 32'd1,  64'hFEDCBA9876543210, 1'b0, 1'b0, 1, 1};
        tbl[3] = '{2'b10, 32'd8,  64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0, 1, 8};
        tbl[4] = '{2'b11, 32'd17, 64'h0000000100000002, 1'b0, 1'b0, 3, 1};
        tbl[5] = '{2'b10, 32'd0,  64'h1234123412341234, 1'b0, 1'b0, 0, 0};
        tbl[6] = '{2'b01, 32'd0,  64'hCAFEBABE00C0FFEE, 1'b0, 1'b1, 4, 8};
        tbl[7] = '{2'b10, 32'd9,  64'h7766554433221100, 1'b0, 1'b0, 2, 1};

        rst_n = 1'b0; start = 1'b0; sel_type = '0; out_length = '0; out_ready = 1'b1;
        x0_i = '0; x1_i = '0; x2_i = '0; x3_i = '0; x4_i = '0; perm_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_bytes", 64'(out_bytes), 64'd0);
        chk("rst_x0", x0_o, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // AEAD128 start is ignored
        drive_start(2'b00, 32'd16, 64'h1);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("aead_busy", 64'(busy), 64'd0);
            chk("aead_valid", 64'(out_valid), 64'd0);
            chk("aead_done", 64'(done), 64'd0);
        end

        // Backpressure: block 1 held for 5 cycles, then 8 + 4 more bytes
        perm_mode = 1'b0;
        out_ready = 1'b0;
        st = {X4, X3, X2, X1, 64'h0011223344556677};
        drive_start(2'b10, 32'd20, 64'h0011223344556677);
        start = 1'b0;
        @(negedge clk);
        held = out_data;
        chk("bp_first_data", held, 64'h0011223344556677);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(out_valid), 64'd1);
            chk("bp_data_held", out_data, held);
            chk("bp_bytes_held", 64'(out_bytes), 64'd8);
            chk("bp_no_perm", x0_o, 64'h0011223344556677);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_perm", 64'(out_valid), 64'd0);
        st = p12(st);
        @(negedge clk);
        chk("bp_blk2_data", out_data, st[63:0]);
        chk("bp_blk2_bytes", 64'(out_bytes), 64'd8);
        chk("bp_blk2_last", 64'(out_last), 64'd0);
        st = p12(st);
        @(negedge clk);
        @(negedge clk);
        chk("bp_blk3_data", out_data, mask(st[63:0], 4));
        chk("bp_blk3_bytes", 64'(out_bytes), 64'd4);
        chk("bp_blk3_last", 64'(out_last), 64'd1);
        @(negedge clk);
        chk("bp_done", 64'(done), 64'd1);
        @(negedge clk);

        // Async reset while block 2 of a Hash256 squeeze is on the bus
        drive_start(2'b01, 32'd0, 64'h0123456789ABCDEF);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_valid_pre", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_bytes", 64'(out_bytes), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        chk("mid_rst_x0", x0_o, 64'd0);
        @(negedge clk);
        chk("mid_rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        run_vec(tbl[7]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
